// File: rtl/q_sampler_if.sv
// q_sampler_if: i_ref/ADC inputs and averaged-measurement outputs of q_sampler.
// The master side (controller/ADC) drives the inputs; the slave side is the sampler.
interface q_sampler_if #(
   parameter int WIDTH = 10
);
   logic [WIDTH-1:0] i_ref;
   logic             adc_valid;
   logic [WIDTH-1:0] adc_data;
   logic [WIDTH-1:0] measured_q;
   logic             ready;

   modport master (output i_ref, adc_valid, adc_data, input measured_q, ready);
   modport slave  (input i_ref, adc_valid, adc_data, output measured_q, ready);
endinterface

// File: rtl/q_sampler.sv
// q_sampler: settle-then-average measurement front end for the secant current controller.
// Any i_ref change restarts the window; otherwise measurements free-run back to back.
module q_sampler #(
   parameter int WIDTH    = 10,
   parameter int AVG_LOG2 = 3,
   parameter int SETTLE   = 16
) (
   input logic        clk,
   input logic        rst,
   q_sampler_if.slave bus
);
   localparam int NSAMP   = 1 << AVG_LOG2;
   localparam int ACC_W   = WIDTH + AVG_LOG2;
   localparam int CNT_MAX = (SETTLE > NSAMP) ? SETTLE : NSAMP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] ACCUM_LAST  = CNT_W'(NSAMP - 1);

   typedef enum logic {ST_SETTLE, ST_ACCUM} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
   logic [WIDTH-1:0] i_ref_q;
   logic [WIDTH-1:0] meas_q, meas_d;
   logic             ready_q, ready_d;
   logic             chg;

   // Sum of 2^AVG_LOG2 WIDTH-bit samples shifted back down always fits WIDTH bits.
   function automatic logic [WIDTH-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
      return WIDTH'(sum >> AVG_LOG2);
   endfunction

   assign chg     = (bus.i_ref != i_ref_q);
   assign acc_sum = acc_q + ACC_W'(bus.adc_data);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      meas_d  = meas_q;
      ready_d = 1'b0;
      if (chg) begin
         // A reference change discards the window in progress, even its final sample.
         state_d = ST_SETTLE;
         cnt_d   = '0;
         acc_d   = '0;
      end else begin
         case (state_q)
            ST_SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  state_d = ST_ACCUM;
                  cnt_d   = '0;
                  acc_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_ACCUM: begin
               if (bus.adc_valid) begin
                  if (cnt_q == ACCUM_LAST) begin
                     meas_d  = avg_trunc(acc_sum);
                     ready_d = 1'b1;
                     state_d = ST_SETTLE;
                     cnt_d   = '0;
                     acc_d   = '0;
                  end else begin
                     acc_d = acc_sum;
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_SETTLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         i_ref_q <= '0;
         meas_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         i_ref_q <= bus.i_ref;
         meas_q  <= meas_d;
         ready_q <= ready_d;
      end
   end

   assign bus.measured_q = meas_q;
   assign bus.ready      = ready_q;
endmodule

// File: tb/tb_q_sampler.sv
// tb_q_sampler: directed scenarios plus randomized traffic against a window-level model,
// on a WIDTH=10/SETTLE=4/AVG_LOG2=2 sampler and a single-sample (AVG_LOG2=0) companion.
`timescale 1ns/1ps
module tb_q_sampler;
   localparam int WIDTH = 10;
   localparam int NI    = 2;
   localparam int S_A = 4, L_A = 2;
   localparam int S_B = 1, L_B = 0;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   bit   chk_en = 1'b0;

   q_sampler_if #(.WIDTH(WIDTH)) bus ();
   q_sampler_if #(.WIDTH(WIDTH)) bus0 ();

   assign bus0.i_ref     = bus.i_ref;
   assign bus0.adc_valid = bus.adc_valid;
   assign bus0.adc_data  = bus.adc_data;

   q_sampler #(.WIDTH(WIDTH), .AVG_LOG2(L_A), .SETTLE(S_A)) dut (
      .clk(clk), .rst(rst), .bus(bus));
   q_sampler #(.WIDTH(WIDTH), .AVG_LOG2(L_B), .SETTLE(S_B)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0));

   always #5 clk = ~clk;

   // Window model: count settle edges, then collect valid samples and average them.
   int               settle_n [NI] = '{S_A, S_B};
   int               navg     [NI] = '{1 << L_A, 1 << L_B};
   int               waited   [NI] = '{0, 0};
   int               nacc     [NI] = '{0, 0};
   int               sum      [NI] = '{0, 0};
   logic [WIDTH-1:0] exp_q    [NI] = '{'0, '0};
   logic             exp_rdy  [NI] = '{1'b0, 1'b0};
   logic [WIDTH-1:0] last_ref = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NI; i++) begin
            waited[i] = 0; nacc[i] = 0; sum[i] = 0;
            exp_q[i] = '0; exp_rdy[i] = 1'b0;
         end
         last_ref = '0;
      end else begin
         for (int i = 0; i < NI; i++) begin
            exp_rdy[i] = 1'b0;
            if (bus.i_ref != last_ref) begin
               waited[i] = 0; nacc[i] = 0; sum[i] = 0;
            end else if (waited[i] < settle_n[i]) begin
               waited[i]++;
            end else if (bus.adc_valid) begin
               sum[i] += int'(bus.adc_data);
               nacc[i]++;
               if (nacc[i] == navg[i]) begin
                  exp_q[i]   = WIDTH'(sum[i] / navg[i]);
                  exp_rdy[i] = 1'b1;
                  waited[i] = 0; nacc[i] = 0; sum[i] = 0;
               end
            end
         end
         last_ref = bus.i_ref;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp_measured_q",  32'(bus.measured_q),  32'(exp_q[0]));
         check("cmp_ready",       32'(bus.ready),       32'(exp_rdy[0]));
         check("cmp_measured_q0", 32'(bus0.measured_q), 32'(exp_q[1]));
         check("cmp_ready0",      32'(bus0.ready),      32'(exp_rdy[1]));
      end
   end

   // Counts rising edges until ready is seen high, returning -1 if the budget runs out.
   task automatic wait_ready(input string name, input int budget, output int edges);
      edges = 0;
      while (edges < budget) begin
         @(posedge clk); #1;
         edges++;
         if (bus.ready === 1'b1) return;
      end
      check({name, "_timeout"}, 32'(edges), 32'(-1));
      edges = -1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish by %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e;
      int rose;
      int nrise;
      rst           = 1'b0;
      bus.i_ref     = '0;
      bus.adc_valid = 1'b0;
      bus.adc_data  = '0;
      #1;
      check("reset_measured_q", 32'(bus.measured_q), 32'd0);
      check("reset_ready",      32'(bus.ready),      32'd0);
      chk_en = 1'b1;
      @(negedge clk); #2 rst = 1'b1;

      // Constant 100 after i_ref 0->5: ready on 8th edge after the change edge, then every 8.
      @(negedge clk);
      bus.i_ref = 10'd5; bus.adc_data = 10'd100; bus.adc_valid = 1'b1;
      wait_ready("t2_first", 20, e);
      check("t2_latency", 32'(e), 32'd9);
      check("t2_value",   32'(bus.measured_q), 32'd100);
      @(posedge clk); #1;
      check("t2_pulse_width", 32'(bus.ready), 32'd0);
      wait_ready("t2_repeat", 20, e);
      check("t2_period", 32'(e), 32'd7);

      // Samples 1,2,3,4 average to 2 after truncation.
      @(negedge clk);
      bus.i_ref = 10'd6; bus.adc_valid = 1'b0;
      @(posedge clk);
      repeat (4) @(posedge clk);
      for (int s = 1; s <= 4; s++) begin
         @(negedge clk);
         bus.adc_data = WIDTH'(s); bus.adc_valid = 1'b1;
      end
      @(negedge clk);
      bus.adc_valid = 1'b0;
      check("t3_ready", 32'(bus.ready), 32'd1);
      check("t3_avg",   32'(bus.measured_q), 32'd2);

      // Sparse valids: 500 during settle ignored, four 40s accepted at edges 6,9,12,15.
      rose = -1; nrise = 0;
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         bus.i_ref     = 10'd7;
         bus.adc_valid = (c % 3 == 0);
         bus.adc_data  = (c <= 4) ? 10'd500 : 10'd40;
         @(posedge clk); #1;
         if (bus.ready === 1'b1) begin
            nrise++;
            if (rose < 0) rose = c;
         end
      end
      check("t4_ready_edge",  32'(rose),  32'd15);
      check("t4_ready_count", 32'(nrise), 32'd1);
      check("t4_value",       32'(bus.measured_q), 32'd40);

      // i_ref changes on the edge of the 4th sample: restart wins, value held.
      @(negedge clk);
      bus.i_ref = 10'd8; bus.adc_data = 10'd100; bus.adc_valid = 1'b1;
      wait_ready("t5_setup", 40, e);
      check("t5_old_value", 32'(bus.measured_q), 32'd100);
      repeat (7) @(posedge clk);
      @(negedge clk);
      bus.i_ref = 10'd9; bus.adc_data = 10'd3;
      @(posedge clk); #1;
      check("t5_no_ready", 32'(bus.ready), 32'd0);
      check("t5_hold",     32'(bus.measured_q), 32'd100);
      wait_ready("t5_new", 20, e);
      check("t5_new_window", 32'(e), 32'd8);
      check("t5_new_value",  32'(bus.measured_q), 32'd3);

      // Full-scale samples must not wrap.
      @(negedge clk);
      bus.i_ref = 10'd10; bus.adc_data = 10'd1023;
      wait_ready("t6", 40, e);
      check("t6_full_scale",    32'(bus.measured_q),  32'd1023);
      check("t6_single_sample", 32'(bus0.measured_q), 32'd1023);

      // Asynchronous reset in the middle of accumulation, then restart from settle.
      @(negedge clk);
      bus.i_ref = 10'd11; bus.adc_data = 10'd77;
      wait_ready("t1_setup", 40, e);
      check("t1_before", 32'(bus.measured_q), 32'd77);
      repeat (6) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("t1_async_q",     32'(bus.measured_q),  32'd0);
      check("t1_async_ready", 32'(bus.ready),       32'd0);
      check("t1_async_q0",    32'(bus0.measured_q), 32'd0);
      @(negedge clk);
      bus.i_ref = 10'd0;
      @(negedge clk); #2 rst = 1'b1;
      wait_ready("t1_release", 20, e);
      check("t1_release_latency", 32'(e), 32'd8);

      // Randomized traffic with occasional reference changes and reset pulses.
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if ($urandom_range(0, 29) == 0) bus.i_ref = WIDTH'($urandom_range(0, 3));
         bus.adc_valid = ($urandom_range(0, 3) != 0);
         bus.adc_data  = ($urandom_range(0, 7) == 0) ? 10'd1023 : WIDTH'($urandom_range(0, 1023));
         if (n % 500 == 499) begin
            #2 rst = 1'b0;
            @(negedge clk);
            #2 rst = 1'b1;
         end
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
